sevensegment_decoder: RTL and testbench
=======================================

# sevensegment_decoder

Receive-side counterpart of the hex seven-segment encoder. Monitors a multiplexed seven-segment display bus (segment lines plus one-hot digit enables), applies a stability filter per sample, and decodes each digit's pattern back to a 4-bit hex value with blank and invalid flags. Used as an on-chip display sniffer for self-test and loopback of the display path on iCE40 designs.

## Interface
- DIGITS, 4: number of multiplexed digits (1–8).
- STABLE_CYCLES, 4: consecutive identical samples required before a commit (2–15).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- segments  input  7  segment lines, active high; bit0=a, bit1=b … bit6=g.
- digit_en  input  DIGITS  digit select; exactly one bit high means a valid strobe.
- value  output  4*DIGITS  decoded nibble per digit; digit i at [4i+3:4i].
- blank  output  DIGITS  digit i last committed as all segments off.
- invalid  output  DIGITS  digit i last committed as an unrecognised pattern.
- update  output  1  one-cycle pulse on each commit.
- update_digit  output  3  index of the digit committed with update; held between pulses.

## Operation
- Decode map, segments to nibble, in hex: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. 00 is blank. Every other code is invalid.
- Input stage registers {digit_en, segments} each cycle. Comparison uses registered samples only.
- FSM states:
  - IDLE: last sample had digit_en not one-hot. The run counter is 0.
  - TRACK: a one-hot sample that differs from the previous sample resets the count to 1. An identical sample increments the count. When the count reaches STABLE_CYCLES, commit and go to HOLD.
  - HOLD: identical samples cause no further commit and the counter saturates. A different one-hot sample goes to TRACK with count 1. A non-one-hot sample goes to IDLE.
- digit_en all-zero or multi-hot from any state goes to IDLE. There is no commit and no output change.
- Commit to digit i:
  - Valid code: value[i] takes the decoded nibble; blank[i]=0; invalid[i]=0.
  - Blank code: value[i]=0; blank[i]=1; invalid[i]=0.
  - Invalid code: value[i] retains its old contents; invalid[i]=1; blank[i]=0.
  - In all three cases update=1 and update_digit=i. Other digits are untouched.
- A change of digit_en with unchanged segments counts as a different sample and restarts tracking.

## Timing
- Reset, synchronous, takes effect at the edge it is sampled high:
  - value=0, blank all 1, invalid=0, update=0, update_digit=0.
  - FSM goes to IDLE, counter=0, sample register cleared to digit_en=0.
- Latency: inputs stable and one-hot from before edge N are sampled at edges N..N+STABLE_CYCLES-1. Outputs change at edge N+STABLE_CYCLES. update is high for exactly the following cycle.
- Minimum dwell for a commit is STABLE_CYCLES clocks. Shorter dwells (glitches, ghosting between digits) produce nothing.
- Back-to-back digits: a new digit can commit STABLE_CYCLES clocks after the previous commit edge. update can therefore pulse at most once per STABLE_CYCLES cycles.
- Reset asserted mid-TRACK discards the partial count. The first post-reset commit needs a full STABLE_CYCLES dwell after reset deasserts.
- Outputs are registered with no combinational path from inputs.

## Test plan
- Reset:
  - Stimulus: hold reset 2 cycles with random inputs, then release with digit_en=0.
  - Required: value=0x0000, blank=4'b1111, invalid=0, update stays 0 for 20 cycles.
- Basic commit:
  - Stimulus: digit_en=4'b0001, segments=7'h5B, held 4 cycles.
  - Required: value[3:0]=2, blank[0]=0. update pulses once, 5 edges after the first presentation, with update_digit=0. No further pulse while held.
- Glitch reject:
  - Stimulus: digit_en=4'b0100 with 7'h7F for 3 cycles, then digit_en=0.
  - Required: no update, value unchanged.
- Invalid and blank:
  - Stimulus: commit 7'h66 on digit 1, then 7'h01 on digit 1, then 7'h00 on digit 1.
  - Required after 7'h01: value[7:4] stays 4 with invalid[1]=1.
  - Required after 7'h00: value[7:4]=0, blank[1]=1, invalid[1]=0. Three update pulses in total.
- Scan loop:
  - Stimulus: cycle digits 0..3 showing 1, 2, 3, F with 6-cycle dwell each; include 2-cycle 0x7F ghosting between digits, and one multi-hot (4'b0011) sample.
  - Required: value=0xF321, exactly 4 updates per scan, ghosting and multi-hot produce no commit.
- Reset mid-operation:
  - Stimulus: assert reset on the 3rd stable cycle of a 7'h07 dwell on digit 2, then keep the input for 4 more cycles.
  - Required: no commit before reset. value[11:8]=7 commits exactly 4 sampled cycles after reset deasserts.

Source files
------------

// File: rtl/sevensegment_decoder.sv
// rtl/sevensegment_decoder.sv - seven-segment display bus sniffer and hex decoder
//
// Watches a multiplexed seven-segment bus. It commits a digit only after the
// same one-hot {digit_en, segments} sample has been seen STABLE_CYCLES times
// in a row. It then decodes the pattern back to a hex nibble.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   segments      segment lines a..g on bits 0..6, active high
//   digit_en      digit strobes, one-hot when valid
//   value         decoded nibble per digit, digit i at [4i+3:4i]
//   blank         digit i last committed as all segments off
//   invalid       digit i last committed as an unrecognised pattern
//   update        one-cycle pulse per commit
//   update_digit  index of the last committed digit
module sevensegment_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            segments,
   input  logic [DIGITS-1:0]     digit_en,
   output logic [4*DIGITS-1:0]   value,
   output logic [DIGITS-1:0]     blank,
   output logic [DIGITS-1:0]     invalid,
   output logic                  update,
   output logic [2:0]            update_digit
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   state_t              state, state_nxt;
   logic [3:0]          cnt, cnt_nxt;
   logic                commit;

   // smp_* is the sample being judged this cycle; prv_* is the one judged
   // in the previous cycle. Inputs are never compared directly.
   logic [DIGITS-1:0]   smp_en, prv_en;
   logic [6:0]          smp_seg, prv_seg;

   logic                smp_onehot;
   logic                same;
   logic [2:0]          idx;
   logic [3:0]          dec_nib;
   logic                dec_valid;
   logic                dec_blank;

   always_comb begin
      smp_onehot = $onehot(smp_en);
      same       = (smp_en == prv_en) && (smp_seg == prv_seg);
      idx        = 3'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (smp_en[i]) idx = 3'(i);
      end
   end

   always_comb begin
      dec_nib   = 4'h0;
      dec_valid = 1'b1;
      dec_blank = 1'b0;
      case (smp_seg)
         7'h3F: dec_nib = 4'h0;
         7'h06: dec_nib = 4'h1;
         7'h5B: dec_nib = 4'h2;
         7'h4F: dec_nib = 4'h3;
         7'h66: dec_nib = 4'h4;
         7'h6D: dec_nib = 4'h5;
         7'h7D: dec_nib = 4'h6;
         7'h07: dec_nib = 4'h7;
         7'h7F: dec_nib = 4'h8;
         7'h6F: dec_nib = 4'h9;
         7'h77: dec_nib = 4'hA;
         7'h7C: dec_nib = 4'hB;
         7'h39: dec_nib = 4'hC;
         7'h5E: dec_nib = 4'hD;
         7'h79: dec_nib = 4'hE;
         7'h71: dec_nib = 4'hF;
         7'h00: begin
            dec_valid = 1'b0;
            dec_blank = 1'b1;
         end
         default: dec_valid = 1'b0;
      endcase
   end

   // Next-state logic. A non-one-hot sample forces IDLE from any state.
   // Coming out of IDLE, the sample always differs from the previous one,
   // because the previous one was not one-hot.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      if (!smp_onehot) begin
         state_nxt = IDLE;
         cnt_nxt   = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = TRACK;
               cnt_nxt   = 4'd1;
            end
            TRACK: begin
               if (!same) begin
                  cnt_nxt = 4'd1;
               end else if (cnt + 4'd1 == STABLE) begin
                  cnt_nxt   = STABLE;
                  commit    = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
            HOLD: begin
               if (!same) begin
                  state_nxt = TRACK;
                  cnt_nxt   = 4'd1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         smp_en  <= '0;
         smp_seg <= 7'h00;
         prv_en  <= '0;
         prv_seg <= 7'h00;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         smp_en  <= digit_en;
         smp_seg <= segments;
         prv_en  <= smp_en;
         prv_seg <= smp_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value        <= '0;
         blank        <= '1;
         invalid      <= '0;
         update       <= 1'b0;
         update_digit <= 3'd0;
      end else begin
         update <= commit;
         if (commit) begin
            update_digit <= idx;
            for (int i = 0; i < DIGITS; i++) begin
               if (smp_en[i]) begin
                  if (dec_blank) begin
                     value[4*i +: 4] <= 4'h0;
                     blank[i]        <= 1'b1;
                     invalid[i]      <= 1'b0;
                  end else if (dec_valid) begin
                     value[4*i +: 4] <= dec_nib;
                     blank[i]        <= 1'b0;
                     invalid[i]      <= 1'b0;
                  end else begin
                     // An unrecognised pattern keeps the last good nibble.
                     blank[i]        <= 1'b0;
                     invalid[i]      <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sevensegment_decoder.sv
// tb/tb_sevensegment_decoder.sv - directed scoreboard bench for sevensegment_decoder
module tb_sevensegment_decoder;

   logic        clk;
   logic        reset;
   logic [6:0]  segments;
   logic [3:0]  digit_en;
   logic [15:0] value;
   logic [3:0]  blank;
   logic [3:0]  invalid;
   logic        update;
   logic [2:0]  update_digit;

   sevensegment_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .segments     (segments),
      .digit_en     (digit_en),
      .value        (value),
      .blank        (blank),
      .invalid      (invalid),
      .update       (update),
      .update_digit (update_digit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          dig;
      logic [15:0] val;
      logic [3:0]  blk;
      logic [3:0]  inv;
      int          when;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          upd_count = 0;
   int          mark;

   logic [15:0] m_value;
   logic [3:0]  m_blank;
   logic [3:0]  m_invalid;
   logic [6:0]  codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [6:0]  scan_codes [4] = '{7'h06, 7'h5B, 7'h4F, 7'h71};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_value   = 16'h0000;
      m_blank   = 4'hF;
      m_invalid = 4'h0;
   endtask

   task automatic push_commit(input int d, input logic [6:0] seg, input int when);
      exp_t e;
      int   hit;
      hit = -1;
      for (int k = 0; k < 16; k++) if (codes[k] == seg) hit = k;
      if (seg == 7'h00) begin
         m_value[4*d +: 4] = 4'h0;
         m_blank[d]        = 1'b1;
         m_invalid[d]      = 1'b0;
      end else if (hit >= 0) begin
         m_value[4*d +: 4] = 4'(hit);
         m_blank[d]        = 1'b0;
         m_invalid[d]      = 1'b0;
      end else begin
         m_blank[d]        = 1'b0;
         m_invalid[d]      = 1'b1;
      end
      e.dig  = d;
      e.val  = m_value;
      e.blk  = m_blank;
      e.inv  = m_invalid;
      e.when = when;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (update) begin
         upd_count++;
         check("update_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("update_digit", 32'(update_digit), 32'(e.dig));
            check("value", 32'(value), 32'(e.val));
            check("blank", 32'(blank), 32'(e.blk));
            check("invalid", 32'(invalid), 32'(e.inv));
            if (e.when != 0) check("commit_cycle", 32'(cyc), 32'(e.when));
         end
      end
   endtask

   task automatic present(input logic [3:0] en, input logic [6:0] seg, input int n);
      digit_en = en;
      segments = seg;
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      reset    = 1'b1;
      segments = 7'h00;
      digit_en = 4'h0;
      model_reset();

      // Reset with random inputs, then release with digit_en idle.
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         segments = 7'($urandom);
         digit_en = 4'($urandom);
         tick();
      end
      reset    = 1'b0;
      digit_en = 4'h0;
      check("reset_value", 32'(value), 32'h0000);
      check("reset_blank", 32'(blank), 32'hF);
      check("reset_invalid", 32'(invalid), 32'h0);
      check("reset_update", 32'(update), 32'h0);
      check("reset_update_digit", 32'(update_digit), 32'h0);
      for (int k = 0; k < 20; k++) tick();
      check("reset_no_updates", 32'(upd_count), 32'd0);

      // Basic commit with exact latency, then a long hold that must not re-commit.
      mark = upd_count;
      push_commit(0, 7'h5B, cyc + 5);
      present(4'b0001, 7'h5B, 10);
      present(4'b0000, 7'h00, 3);
      check("basic_one_pulse", 32'(upd_count - mark), 32'd1);
      check("basic_value", 32'(value), 32'h0002);
      check("basic_blank0", 32'(blank[0]), 32'd0);

      // Glitch shorter than the dwell.
      mark = upd_count;
      present(4'b0100, 7'h7F, 3);
      present(4'b0000, 7'h00, 6);
      check("glitch_no_update", 32'(upd_count - mark), 32'd0);
      check("glitch_value", 32'(value), 32'h0002);

      // Valid, then invalid, then blank on digit 1.
      mark = upd_count;
      push_commit(1, 7'h66, 0);
      present(4'b0010, 7'h66, 6);
      push_commit(1, 7'h01, 0);
      present(4'b0010, 7'h01, 6);
      check("invalid_keeps_nibble", 32'(value[7:4]), 32'h4);
      check("invalid_flag", 32'(invalid[1]), 32'd1);
      push_commit(1, 7'h00, 0);
      present(4'b0010, 7'h00, 6);
      present(4'b0000, 7'h00, 3);
      check("blank_nibble", 32'(value[7:4]), 32'h0);
      check("blank_flag", 32'(blank[1]), 32'd1);
      check("blank_invalid_clear", 32'(invalid[1]), 32'd0);
      check("inv_blank_pulses", 32'(upd_count - mark), 32'd3);

      // Two scans with ghosting and a multi-hot sample.
      for (int s = 0; s < 2; s++) begin
         mark = upd_count;
         for (int d = 0; d < 4; d++) begin
            present(4'(1 << d), 7'h7F, 2);
            push_commit(d, scan_codes[d], 0);
            present(4'(1 << d), scan_codes[d], 6);
            if (d == 0) present(4'b0011, 7'h06, 1);
         end
         present(4'b0000, 7'h00, 2);
         check("scan_updates", 32'(upd_count - mark), 32'd4);
         check("scan_value", 32'(value), 32'hF321);
      end

      // Reset on the third stable cycle of a dwell, then a full dwell afterwards.
      mark = upd_count;
      present(4'b0100, 7'h07, 2);
      reset = 1'b1;
      tick();
      model_reset();
      check("midreset_no_commit", 32'(upd_count - mark), 32'd0);
      check("midreset_value", 32'(value), 32'h0000);
      check("midreset_blank", 32'(blank), 32'hF);
      reset = 1'b0;
      push_commit(2, 7'h07, cyc + 5);
      present(4'b0100, 7'h07, 4);
      present(4'b0000, 7'h00, 4);
      check("midreset_value_after", 32'(value), 32'h0700);
      check("midreset_one_commit", 32'(upd_count - mark), 32'd1);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
